// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared single-port instruction/data memory.
// One transaction at a time: IDLE grants, ACCESS drives the memory for LATENCY cycles, RESP pulses done.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LATENCY  = 2,
  parameter int ARB_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [DATA_W/8-1:0] core_be,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  output logic                core_done,
  output logic [DATA_W-1:0]   core_rdata,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [DATA_W/8-1:0] dbg_be,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  output logic                dbg_done,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic              last_dbg;
  logic              win_dbg;
  logic              we_r;
  logic [BE_W-1:0]   be_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;

  logic              any_req;
  logic              pick_dbg;
  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    any_req = core_req | dbg_req;
    // Round-robin favours whoever did not win last; last_dbg resets high so core wins the first tie.
    if (ARB_MODE == 1) pick_dbg = dbg_req;
    else               pick_dbg = dbg_req & (~core_req | ~last_dbg);
    sel_we    = pick_dbg ? dbg_we    : core_we;
    sel_be    = pick_dbg ? dbg_be    : core_be;
    sel_addr  = pick_dbg ? dbg_addr  : core_addr;
    sel_wdata = pick_dbg ? dbg_wdata : core_wdata;
    state_nx  = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_dbg   <= 1'b1;
      win_dbg    <= 1'b0;
      we_r       <= 1'b0;
      be_r       <= '0;
      addr_r     <= '0;
      wdata_r    <= '0;
      core_rdata <= '0;
      dbg_rdata  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (any_req) begin
            win_dbg  <= pick_dbg;
            last_dbg <= pick_dbg;
            cnt      <= CNT_INIT;
            we_r     <= sel_we;
            be_r     <= sel_we ? sel_be : '1;
            addr_r   <= sel_addr;
            wdata_r  <= sel_wdata;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!we_r) begin
            if (win_dbg) dbg_rdata  <= mem_rdata;
            else         core_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & we_r;
  assign mem_be    = be_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign busy      = (state != IDLE);
  assign core_done = (state == RESP) & ~win_dbg;
  assign dbg_done  = (state == RESP) & win_dbg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance 0 = round-robin LATENCY 2,
// instance 1 = dbg priority LATENCY 2, instance 2 = round-robin LATENCY 1; inputs are shared.
module tb_mem_port_arbiter;
  logic        clk;
  logic        reset;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [3:0]  core_be, dbg_be;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata, mem_rdata;

  logic        core_done [3];
  logic [31:0] core_rdata [3];
  logic        dbg_done [3];
  logic [31:0] dbg_rdata [3];
  logic        mem_en [3];
  logic        mem_we [3];
  logic [3:0]  mem_be [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata [3];
  logic        busy [3];

  int total = 0;
  int bad   = 0;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .LATENCY(i == 2 ? 1 : 2),
      .ARB_MODE(i == 1 ? 1 : 0)
    ) dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_be(core_be),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .core_done(core_done[i]), .core_rdata(core_rdata[i]),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be),
      .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_done(dbg_done[i]), .dbg_rdata(dbg_rdata[i]),
      .mem_en(mem_en[i]), .mem_we(mem_we[i]), .mem_be(mem_be[i]),
      .mem_addr(mem_addr[i]), .mem_wdata(mem_wdata[i]),
      .mem_rdata(mem_rdata), .busy(busy[i])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    reset = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_be = 4'h0; core_addr = '0; core_wdata = '0;
    dbg_req = 1'b0;  dbg_we = 1'b0;  dbg_be = 4'h0;  dbg_addr = '0;  dbg_wdata = '0;
    mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({core_done[i], dbg_done[i], mem_en[i], mem_we[i], busy[i]} !== 5'b0 ||
          mem_be[i] !== 4'h0 || mem_addr[i] !== 32'h0 || mem_wdata[i] !== 32'h0 ||
          core_rdata[i] !== 32'h0 || dbg_rdata[i] !== 32'h0) begin
        bad++;
        $display("FAIL reset_state inst%0d: done=%b/%b en=%b we=%b busy=%b be=%h addr=%h wdata=%h rd=%h/%h required all zero",
                 i, core_done[i], dbg_done[i], mem_en[i], mem_we[i], busy[i], mem_be[i],
                 mem_addr[i], mem_wdata[i], core_rdata[i], dbg_rdata[i]);
      end
    end
  endtask

  task automatic test_core_read();
    int en_cnt = 0;
    int done_cyc = -1;
    do_reset();
    mem_rdata = 32'h00C0FFEE;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40; core_be = 4'h0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_en[0]) begin
        en_cnt++;
        total++;
        if (mem_we[0] !== 1'b0 || mem_be[0] !== 4'hF || mem_addr[0] !== 32'h40) begin
          bad++;
          $display("FAIL core_read_drive: we=%b be=%h addr=%h required 0/f/00000040", mem_we[0], mem_be[0], mem_addr[0]);
        end
      end
      if (core_done[0] && done_cyc < 0) begin
        done_cyc = c;
        core_req = 1'b0;
      end
    end
    total++;
    if (en_cnt !== 2) begin bad++; $display("FAIL core_read_en_cycles: got %0d required 2", en_cnt); end
    total++;
    if (done_cyc !== 3) begin bad++; $display("FAIL core_read_latency: done at %0d required 3", done_cyc); end
    total++;
    if (core_rdata[0] !== 32'h00C0FFEE) begin
      bad++; $display("FAIL core_read_data: got %h required 00c0ffee", core_rdata[0]);
    end
  endtask

  task automatic test_dbg_write();
    int we_cnt = 0;
    int done_cyc = -1;
    mem_rdata = 32'h12345678;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h100; dbg_wdata = 32'hDEADBEEF; dbg_be = 4'b0011;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_we[0]) begin
        we_cnt++;
        total++;
        if (mem_en[0] !== 1'b1 || mem_be[0] !== 4'b0011 || mem_addr[0] !== 32'h100 ||
            mem_wdata[0] !== 32'hDEADBEEF) begin
          bad++;
          $display("FAIL dbg_write_drive: en=%b be=%b addr=%h wdata=%h required 1/0011/00000100/deadbeef",
                   mem_en[0], mem_be[0], mem_addr[0], mem_wdata[0]);
        end
      end
      if (core_done[0]) begin bad++; total++; $display("FAIL dbg_write_core_done: got 1 required 0"); end
      if (dbg_done[0] && done_cyc < 0) begin
        done_cyc = c;
        dbg_req = 1'b0;
      end
    end
    dbg_we = 1'b0;
    total++;
    if (we_cnt !== 2) begin bad++; $display("FAIL dbg_write_we_cycles: got %0d required 2", we_cnt); end
    total++;
    if (done_cyc !== 3) begin bad++; $display("FAIL dbg_write_latency: done at %0d required 3", done_cyc); end
    total++;
    if (dbg_rdata[0] !== 32'h0) begin bad++; $display("FAIL dbg_write_rdata: got %h required 00000000", dbg_rdata[0]); end
    total++;
    if (core_rdata[0] !== 32'h00C0FFEE) begin
      bad++; $display("FAIL dbg_write_core_rdata_hold: got %h required 00c0ffee", core_rdata[0]);
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    int who;
    do_reset();
    mem_rdata = 32'h0000AAAA;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h200;
    dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 32'h300;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (core_done[0] && dbg_done[0]) begin
        bad++; total++; $display("FAIL rr_both_done: cycle %0d both done high required one", c);
      end else if (core_done[0] || dbg_done[0]) begin
        who = dbg_done[0] ? 1 : 0;
        total++;
        if (n < 4 && (who !== (n % 2) || c !== 3 + 4 * n)) begin
          bad++;
          $display("FAIL rr_order: grant %0d went to %0d at cycle %0d required %0d at cycle %0d",
                   n, who, c, n % 2, 3 + 4 * n);
        end
        total++;
        if (mem_addr[0] !== (who == 1 ? 32'h300 : 32'h200)) begin
          bad++; $display("FAIL rr_addr: grant %0d addr %h required %h", n, mem_addr[0], (who == 1 ? 32'h300 : 32'h200));
        end
        n++;
      end
    end
    core_req = 1'b0; dbg_req = 1'b0;
    total++;
    if (n !== 4) begin bad++; $display("FAIL rr_count: got %0d transactions required 4", n); end
  endtask

  task automatic test_fixed_priority();
    int dn = 0;
    int cn = 0;
    do_reset();
    mem_rdata = 32'h0000BBBB;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h200;
    dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 32'h300;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (dbg_done[1]) dn++;
      if (core_done[1]) cn++;
    end
    core_req = 1'b0; dbg_req = 1'b0;
    total++;
    if (dn !== 4) begin bad++; $display("FAIL prio_dbg_count: got %0d required 4", dn); end
    total++;
    if (cn !== 0) begin bad++; $display("FAIL prio_core_count: got %0d required 0", cn); end
    total++;
    if (dbg_rdata[1] !== 32'h0000BBBB) begin bad++; $display("FAIL prio_dbg_rdata: got %h required 0000bbbb", dbg_rdata[1]); end
  endtask

  task automatic test_reset_mid_access();
    int done_cyc = -1;
    do_reset();
    mem_rdata = 32'hA5A50001;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (core_done[0]) core_req = 1'b0;
    end
    total++;
    if (core_rdata[0] !== 32'hA5A50001) begin bad++; $display("FAIL mid_pre_read: got %h required a5a50001", core_rdata[0]); end
    mem_rdata = 32'h5A5A0002;
    core_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (mem_en[0] !== 1'b1) begin bad++; $display("FAIL mid_second_access: en=%b required 1", mem_en[0]); end
    reset = 1'b1; core_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (mem_en[0] !== 1'b0 || busy[0] !== 1'b0 || core_done[0] !== 1'b0 || core_rdata[0] !== 32'h0) begin
      bad++;
      $display("FAIL mid_after_reset: en=%b busy=%b done=%b rdata=%h required 0/0/0/00000000",
               mem_en[0], busy[0], core_done[0], core_rdata[0]);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (core_done[0] || dbg_done[0]) begin bad++; total++; $display("FAIL mid_spurious_done: got 1 required 0"); end
    end
    mem_rdata = 32'h0BADF00D;
    core_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (core_done[0] && done_cyc < 0) begin
        done_cyc = c;
        core_req = 1'b0;
      end
    end
    total++;
    if (done_cyc !== 3) begin bad++; $display("FAIL mid_fresh_latency: done at %0d required 3", done_cyc); end
    total++;
    if (core_rdata[0] !== 32'h0BADF00D) begin bad++; $display("FAIL mid_fresh_data: got %h required 0badf00d", core_rdata[0]); end
  endtask

  task automatic test_latency1_hold();
    int en_cnt = 0;
    int done_cyc = -1;
    do_reset();
    mem_rdata = 32'h11112222;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (mem_en[2]) en_cnt++;
      if (c == 1) core_addr = 32'h20;
      if (core_done[2] && done_cyc < 0) begin
        done_cyc = c;
        core_req = 1'b0;
        total++;
        if (mem_addr[2] !== 32'h10) begin bad++; $display("FAIL lat1_addr: got %h required 00000010", mem_addr[2]); end
      end
    end
    total++;
    if (en_cnt !== 1) begin bad++; $display("FAIL lat1_en_cycles: got %0d required 1", en_cnt); end
    total++;
    if (done_cyc !== 2) begin bad++; $display("FAIL lat1_latency: done at %0d required 2", done_cyc); end
    total++;
    if (core_rdata[2] !== 32'h11112222) begin bad++; $display("FAIL lat1_data: got %h required 11112222", core_rdata[2]); end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_dbg_write();
    test_round_robin();
    test_fixed_priority();
    test_reset_mid_access();
    test_latency1_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
